// File: rtl/hazard_unit.sv
// Hazard control for the five-stage integer pipeline: load-use stall, E-stage
// operand forwarding, redirect flush, and two saturating event counters.
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic             memreadE,
   input  logic [4:0]       rdM,
   input  logic             regwriteM,
   input  logic [4:0]       rdW,
   input  logic             regwriteW,
   input  logic             pcsrcE,
   output logic             stallF,
   output logic             stallD,
   output logic             flushD,
   output logic             flushE,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwdSel_e;

   logic             lwStall;
   logic [CNT_W-1:0] stallCntQ;
   logic [CNT_W-1:0] flushCntQ;

   // The closer stage (M) holds the newer value of a register, so it wins over W.
   function automatic fwdSel_e pickFwd(
      input logic [4:0] rs,
      input logic [4:0] rdMem,
      input logic       wrMem,
      input logic [4:0] rdWb,
      input logic       wrWb
   );
      fwdSel_e sel;
      sel = FWD_RF;
      if (rs != 5'd0 && wrMem && rs == rdMem) begin
         sel = FWD_M;
      end else if (rs != 5'd0 && wrWb && rs == rdWb) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

   // NOTE: every signal driven from always_comb gets a default first so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      lwStall   = 1'b0;
      stallF    = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;

      lwStall = memreadE && (rdE != 5'd0) && ((rs1D == rdE) || (rs2D == rdE));

      // A redirect discards the stalled instruction anyway, so it overrides the stall.
      stallF = lwStall && !pcsrcE;
      stallD = lwStall && !pcsrcE;
      flushD = pcsrcE;
      flushE = lwStall || pcsrcE;

      forwardAE = pickFwd(rs1E, rdM, regwriteM, rdW, regwriteW);
      forwardBE = pickFwd(rs2E, rdM, regwriteM, rdW, regwriteW);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCntQ <= '0;
      end else if (stallD && stallCntQ != '1) begin
         stallCntQ <= stallCntQ + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flushCntQ <= '0;
      end else if (flushD && flushCntQ != '1) begin
         flushCntQ <= flushCntQ + CNT_W'(1);
      end
   end

   assign stall_cnt = stallCntQ;
   assign flush_cnt = flushCntQ;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed plan vectors then random traffic,
// checked against a rule-level model; a CNT_W=4 instance exercises saturation.
module tb_hazard_unit;

   typedef struct {
      logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
      logic       memreadE, regwriteM, regwriteW, pcsrcE;
   } vec_t;

   typedef struct {
      bit         stallF, stallD, flushD, flushE;
      logic [1:0] fwdA, fwdB;
      longint     stallCnt, flushCnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
   logic       memreadE = 1'b0, regwriteM = 1'b0, regwriteW = 1'b0, pcsrcE = 1'b0;

   logic        stallF, stallD, flushD, flushE;
   logic [1:0]  forwardAE, forwardBE;
   logic [31:0] stall_cnt, flush_cnt;
   logic        sStallF, sStallD, sFlushD, sFlushE;
   logic [1:0]  sForwardAE, sForwardBE;
   logic [3:0]  sStallCnt, sFlushCnt;

   int checks = 0;
   int errors = 0;
   exp_t sbQ[$];

   longint modelStall = 0;
   longint modelFlush = 0;
   bit     prevStall = 1'b0;
   bit     prevFlush = 1'b0;

   always #5 clk = ~clk;

   hazard_unit #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
      .memreadE(memreadE), .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW),
      .regwriteW(regwriteW), .pcsrcE(pcsrcE),
      .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_unit #(.CNT_W(4)) dutSmall (
      .clk(clk), .rst_n(rst_n),
      .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
      .memreadE(memreadE), .rdM(rdM), .regwriteM(regwriteM), .rdW(rdW),
      .regwriteW(regwriteW), .pcsrcE(pcsrcE),
      .stallF(sStallF), .stallD(sStallD), .flushD(sFlushD), .flushE(sFlushE),
      .forwardAE(sForwardAE), .forwardBE(sForwardBE),
      .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
   );

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [1:0] refFwd(input logic [4:0] rs, input vec_t v);
      if (rs == 0) return 2'b00;
      if (v.regwriteM && rs == v.rdM) return 2'b10;
      if (v.regwriteW && rs == v.rdW) return 2'b01;
      return 2'b00;
   endfunction

   function automatic longint sat4(input longint n);
      return (n > 15) ? 15 : n;
   endfunction

   // Apply one vector shortly after a rising edge; optionally pulse reset low
   // for part of this cycle, never spanning a clock edge.
   task automatic applyVec(input vec_t v, input bit pulseRst);
      exp_t e;
      bit   lw;
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (prevStall) modelStall++;
         if (prevFlush) modelFlush++;
      end
      rst_n = 1'b1;
      rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
      rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
      memreadE = v.memreadE; regwriteM = v.regwriteM;
      regwriteW = v.regwriteW; pcsrcE = v.pcsrcE;
      if (pulseRst) begin
         rst_n = 1'b0;
         modelStall = 0;
         modelFlush = 0;
      end
      lw = v.memreadE && v.rdE != 0 && (v.rs1D == v.rdE || v.rs2D == v.rdE);
      e.stallF   = lw && !v.pcsrcE;
      e.stallD   = lw && !v.pcsrcE;
      e.flushD   = v.pcsrcE;
      e.flushE   = lw || v.pcsrcE;
      e.fwdA     = refFwd(v.rs1E, v);
      e.fwdB     = refFwd(v.rs2E, v);
      e.stallCnt = modelStall;
      e.flushCnt = modelFlush;
      prevStall  = e.stallD;
      prevFlush  = e.flushD;
      sbQ.push_back(e);
      if (pulseRst) begin
         #6 rst_n = 1'b1;
      end
   endtask

   function automatic vec_t mkVec(input logic [4:0] r1D, r2D, r1E, r2E, rE, rM, rW,
                                  input logic mr, wm, ww, pc);
      vec_t v;
      v.rs1D = r1D; v.rs2D = r2D; v.rs1E = r1E; v.rs2E = r2E;
      v.rdE = rE; v.rdM = rM; v.rdW = rW;
      v.memreadE = mr; v.regwriteM = wm; v.regwriteW = ww; v.pcsrcE = pc;
      return v;
   endfunction

   function automatic logic [4:0] randReg();
      return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
   endfunction

   // Monitor: compares whatever the DUT presents on the falling edge with the
   // oldest outstanding expectation.
   always @(negedge clk) begin
      if (sbQ.size() > 0) begin
         exp_t e;
         e = sbQ.pop_front();
         check("stallF", stallF, e.stallF);
         check("stallD", stallD, e.stallD);
         check("flushD", flushD, e.flushD);
         check("flushE", flushE, e.flushE);
         check("forwardAE", forwardAE, e.fwdA);
         check("forwardBE", forwardBE, e.fwdB);
         check("stall_cnt", stall_cnt, e.stallCnt);
         check("flush_cnt", flush_cnt, e.flushCnt);
         check("stall_cnt_w4", sStallCnt, sat4(e.stallCnt));
         check("flush_cnt_w4", sFlushCnt, sat4(e.flushCnt));
         check("stallD_w4", sStallD, e.stallD);
      end
   end

   initial begin
      int waitCycles;
      vec_t v;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed plan vectors.
      applyVec(mkVec(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      applyVec(mkVec(3, 4, 0, 0, 3, 0, 0, 1, 0, 0, 0), 1'b0);
      applyVec(mkVec(5, 6, 0, 0, 6, 0, 0, 1, 0, 0, 0), 1'b0);
      applyVec(mkVec(3, 4, 0, 0, 4, 0, 0, 1, 0, 0, 0), 1'b0);
      applyVec(mkVec(7, 8, 0, 0, 9, 0, 0, 1, 0, 0, 0), 1'b0);
      applyVec(mkVec(0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0), 1'b0);
      applyVec(mkVec(3, 4, 0, 0, 3, 0, 0, 1, 0, 0, 1), 1'b0);
      applyVec(mkVec(1, 1, 5, 0, 0, 5, 5, 0, 1, 1, 0), 1'b0);
      applyVec(mkVec(1, 1, 5, 0, 0, 5, 5, 0, 0, 1, 0), 1'b0);
      applyVec(mkVec(1, 1, 5, 0, 0, 7, 0, 0, 1, 1, 0), 1'b0);
      applyVec(mkVec(2, 2, 0, 9, 0, 9, 9, 0, 1, 1, 0), 1'b0);
      applyVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      // Reset pulse between edges with nonzero counters.
      applyVec(mkVec(3, 4, 0, 0, 3, 0, 0, 1, 0, 0, 0), 1'b1);
      // Long stall run drives the 4-bit counters into saturation.
      for (int i = 0; i < 20; i++) begin
         applyVec(mkVec(10, 11, 0, 0, 11, 0, 0, 1, 0, 0, 0), 1'b0);
      end
      for (int i = 0; i < 18; i++) begin
         applyVec(mkVec(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b0);
      end
      applyVec(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

      // Random traffic biased toward low register numbers so matches are frequent.
      for (int i = 0; i < 1500; i++) begin
         v = mkVec(randReg(), randReg(), randReg(), randReg(), randReg(), randReg(), randReg(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
         applyVec(v, ($urandom_range(0, 299) == 0));
      end

      waitCycles = 0;
      while (sbQ.size() > 0 && waitCycles < 10) begin
         @(posedge clk);
         waitCycles++;
      end
      check("scoreboard_drained", sbQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
